// File: rtl/write_pair_packer_if.sv
// Stream-in / pair-write bus between an upstream source, the packer and the buffer.
// The packer takes the slave side; the source/buffer model takes the master side.
interface write_pair_packer_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic             read_pop;
   logic [WIDTH-1:0] write_data_1;
   logic [WIDTH-1:0] write_data_2;
   logic             write_enable;
   logic             write_partial;
   logic [CW-1:0]    credit;
   logic             credit_error;

   modport slave (
      input  in_data, in_valid, flush, read_pop,
      output in_ready, write_data_1, write_data_2, write_enable, write_partial,
             credit, credit_error
   );

   modport master (
      output in_data, in_valid, flush, read_pop,
      input  in_ready, write_data_1, write_data_2, write_enable, write_partial,
             credit, credit_error
   );
endinterface

// File: rtl/write_pair_packer.sv
// Packs a one-word-per-cycle stream into word pairs for a double-write buffer,
// gating each pair write on a credit counter that mirrors the buffer's free slots.
module write_pair_packer #(
   parameter int                 WIDTH     = 16,
   parameter int                 DEPTH     = 8,
   parameter logic [WIDTH-1:0]   PAD_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   write_pair_packer_if.slave    bus
);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HALF = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] hold_1_q,  hold_1_d;
   logic [WIDTH-1:0] hold_2_q,  hold_2_d;
   logic             part_q,    part_d;
   logic [CW-1:0]    credit_q,  credit_d;
   logic             cerr_q,    cerr_d;
   logic [WIDTH-1:0] wd_1_q,    wd_1_d;
   logic [WIDTH-1:0] wd_2_q,    wd_2_d;
   logic             we_q,      we_d;
   logic             wp_q,      wp_d;

   logic             xfer;
   logic             can_emit;
   logic             pop_ok;
   logic             pair_formed;
   logic [WIDTH-1:0] pair_2;
   logic             pair_part;

   assign bus.in_ready = (state_q != S_FULL);
   assign xfer         = bus.in_valid & bus.in_ready;
   // Only the registered credit gates an emit; a same-cycle pop is not counted yet.
   assign can_emit     = (credit_q >= CW'(2));
   assign pop_ok       = bus.read_pop & (credit_q != CW'(DEPTH));

   always_comb begin
      state_d     = state_q;
      hold_1_d    = hold_1_q;
      hold_2_d    = hold_2_q;
      part_d      = part_q;
      wd_1_d      = wd_1_q;
      wd_2_d      = wd_2_q;
      we_d        = 1'b0;
      wp_d        = 1'b0;
      pair_formed = 1'b0;
      pair_2      = bus.in_data;
      pair_part   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               hold_1_d = bus.in_data;
               state_d  = S_HALF;
            end
         end
         S_HALF: begin
            // A real second word takes priority over flush in the same cycle.
            if (xfer) begin
               pair_formed = 1'b1;
            end else if (bus.flush) begin
               pair_formed = 1'b1;
               pair_2      = PAD_VALUE;
               pair_part   = 1'b1;
            end
            if (pair_formed) begin
               if (can_emit) begin
                  wd_1_d  = hold_1_q;
                  wd_2_d  = pair_2;
                  wp_d    = pair_part;
                  we_d    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  hold_2_d = pair_2;
                  part_d   = pair_part;
                  state_d  = S_FULL;
               end
            end
         end
         S_FULL: begin
            if (can_emit) begin
               wd_1_d  = hold_1_q;
               wd_2_d  = hold_2_q;
               wp_d    = part_q;
               we_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      credit_d = credit_q - (we_d ? CW'(2) : CW'(0)) + (pop_ok ? CW'(1) : CW'(0));
      cerr_d   = cerr_q | (bus.read_pop & ~pop_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         hold_1_q <= '0;
         hold_2_q <= '0;
         part_q   <= 1'b0;
         credit_q <= CW'(DEPTH);
         cerr_q   <= 1'b0;
         wd_1_q   <= '0;
         wd_2_q   <= '0;
         we_q     <= 1'b0;
         wp_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_1_q <= hold_1_d;
         hold_2_q <= hold_2_d;
         part_q   <= part_d;
         credit_q <= credit_d;
         cerr_q   <= cerr_d;
         wd_1_q   <= wd_1_d;
         wd_2_q   <= wd_2_d;
         we_q     <= we_d;
         wp_q     <= wp_d;
      end
   end

   assign bus.write_data_1  = wd_1_q;
   assign bus.write_data_2  = wd_2_q;
   assign bus.write_enable  = we_q;
   assign bus.write_partial = wp_q;
   assign bus.credit        = credit_q;
   assign bus.credit_error  = cerr_q;

endmodule

// File: tb/tb_write_pair_packer.sv
// Directed bench for write_pair_packer: pairing, credit gating, flush padding,
// pop/credit interaction and asynchronous reset.
module tb_write_pair_packer;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   write_pair_packer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   write_pair_packer #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .PAD_VALUE (16'd0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic fl, input logic pop);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.flush    = fl;
      bus.read_pop = pop;
   endtask

   task automatic chk_we(input string tag, input logic we, input int cr);
      check({tag, ".we"},     32'(bus.write_enable), 32'(we));
      check({tag, ".credit"}, 32'(bus.credit),       32'(cr));
   endtask

   task automatic chk_pair(input string tag, input int d1, input int d2, input logic part);
      check({tag, ".d1"},   32'(bus.write_data_1),  32'(d1));
      check({tag, ".d2"},   32'(bus.write_data_2),  32'(d2));
      check({tag, ".part"}, 32'(bus.write_partial), 32'(part));
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b0;
      #3;
      reset = 1'b1;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      drive(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b0;
      #12;

      // 1: reset values
      check("rst.credit", 32'(bus.credit),        32'd8);
      check("rst.ready",  32'(bus.in_ready),      32'd1);
      check("rst.we",     32'(bus.write_enable),  32'd0);
      check("rst.cerr",   32'(bus.credit_error),  32'd0);
      check("rst.part",   32'(bus.write_partial), 32'd0);
      check("rst.d1",     32'(bus.write_data_1),  32'd0);
      check("rst.d2",     32'(bus.write_data_2),  32'd0);
      reset = 1'b1;
      step();

      // 2: continuous stream 25,50,75,100
      drive(1'b1, 16'd25, 1'b0, 1'b0);  step(); chk_we("s2.w25", 1'b0, 8);
      check("s2.ready0", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 16'd50, 1'b0, 1'b0);  step(); chk_we("s2.w50", 1'b1, 6);
      chk_pair("s2.p0", 25, 50, 1'b0);
      check("s2.ready1", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 16'd75, 1'b0, 1'b0);  step(); chk_we("s2.w75", 1'b0, 6);
      drive(1'b1, 16'd100, 1'b0, 1'b0); step(); chk_we("s2.w100", 1'b1, 4);
      chk_pair("s2.p1", 75, 100, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);      step(); chk_we("s2.idle", 1'b0, 4);
      chk_pair("s2.hold", 75, 100, 1'b0);

      // 3: fill to zero credit, then FULL stall released by two pops
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b0);
         step();
      end
      chk_we("s3.fill", 1'b1, 0);
      chk_pair("s3.p3", 7, 8, 1'b0);
      drive(1'b1, 16'd9, 1'b0, 1'b0);  step(); chk_we("s3.w9", 1'b0, 0);
      drive(1'b1, 16'd10, 1'b0, 1'b0); step(); chk_we("s3.w10", 1'b0, 0);
      check("s3.full_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 16'd99, 1'b0, 1'b1); step(); chk_we("s3.pop1", 1'b0, 1);
      check("s3.pop1_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b0, '0, 1'b1, 1'b1);     step(); chk_we("s3.pop2", 1'b0, 2);
      check("s3.pop2_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b0, '0, 1'b0, 1'b0);     step(); chk_we("s3.emit", 1'b1, 0);
      chk_pair("s3.pf", 9, 10, 1'b0);
      check("s3.emit_ready", 32'(bus.in_ready), 32'd1);

      // 4: flush padding, flush in IDLE, flush with a real second word
      do_reset();
      drive(1'b1, 16'd125, 1'b0, 1'b0); step(); chk_we("s4.w125", 1'b0, 8);
      drive(1'b0, '0, 1'b1, 1'b0);      step(); chk_we("s4.flush", 1'b1, 6);
      chk_pair("s4.pf", 125, 0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0);      step(); chk_we("s4.idleflush", 1'b0, 6);
      check("s4.idlepart", 32'(bus.write_partial), 32'd0);
      drive(1'b1, 16'd7, 1'b0, 1'b0);   step(); chk_we("s4.w7", 1'b0, 6);
      drive(1'b1, 16'd8, 1'b1, 1'b0);   step(); chk_we("s4.w8fl", 1'b1, 4);
      chk_pair("s4.p78", 7, 8, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);      step(); chk_we("s4.after", 1'b0, 4);
      chk_pair("s4.hold", 7, 8, 1'b0);

      // 5: emit and pop in the same cycle at credit 2
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 16'(i + 40), 1'b0, 1'b0);
         step();
      end
      chk_we("s5.pre", 1'b1, 2);
      drive(1'b1, 16'd47, 1'b0, 1'b0); step(); chk_we("s5.w47", 1'b0, 2);
      drive(1'b1, 16'd48, 1'b0, 1'b1); step(); chk_we("s5.emitpop", 1'b1, 1);
      chk_pair("s5.p", 47, 48, 1'b0);

      // 6: pop at full credit is dropped and sticky-flagged; async reset in HALF
      do_reset();
      drive(1'b0, '0, 1'b0, 1'b1);     step(); chk_we("s6.pop", 1'b0, 8);
      check("s6.cerr", 32'(bus.credit_error), 32'd1);
      drive(1'b0, '0, 1'b0, 1'b0);     step();
      check("s6.cerr_sticky", 32'(bus.credit_error), 32'd1);
      drive(1'b1, 16'd11, 1'b0, 1'b0); step(); chk_we("s6.w11", 1'b0, 8);
      drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("s6.async_cerr", 32'(bus.credit_error), 32'd0);
      check("s6.async_ready", 32'(bus.in_ready), 32'd1);
      chk_we("s6.async", 1'b0, 8);
      step();
      reset = 1'b1;
      chk_we("s6.inrst", 1'b0, 8);
      drive(1'b1, 16'd21, 1'b0, 1'b0); step(); chk_we("s6.w21", 1'b0, 8);
      drive(1'b1, 16'd22, 1'b0, 1'b0); step(); chk_we("s6.w22", 1'b1, 6);
      chk_pair("s6.fresh", 21, 22, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);     step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
